// File: rtl/avaliador_limiar.sv
// avaliador_limiar: open-list node store with a sequential minimum-criterion
// scan and a threshold approval mask.
//
// Ports:
//   clk_in, rst_in            clock and asynchronous active-high reset
//   escrever_in, limpar_in    write or invalidate the slot at endereco_in
//   endereco_in               slot address
//   distancia_in             distance stored on a write
//   menor_vizinho_in         smallest neighbour cost stored on a write
//   avaliar_in               start an evaluation (taken only when idle)
//   modo_in                  0 = fixed threshold, 1 = minimum + margin
//   limiar_in, margem_in     fixed threshold and margin, sampled at start
//   ocupado_out              evaluation in progress
//   pronto_out               one-cycle pulse when the results are valid
//   aprovados_out            per-slot approval mask
//   menor_criterio_out       minimum criterion found
//   menor_indice_out         slot holding the minimum
//   vazio_out                no valid slot at evaluation time
module avaliador_limiar #(
  parameter int NUM_ATIVOS  = 24,
  parameter int DIST_WIDTH  = 8,
  parameter int CUSTO_WIDTH = 8,
  parameter int ADDR_WIDTH  = $clog2(NUM_ATIVOS),
  parameter int CRIT_WIDTH  =
    ((DIST_WIDTH > CUSTO_WIDTH) ? DIST_WIDTH : CUSTO_WIDTH) + 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   escrever_in,
  input  logic                   limpar_in,
  input  logic [ADDR_WIDTH-1:0]  endereco_in,
  input  logic [DIST_WIDTH-1:0]  distancia_in,
  input  logic [CUSTO_WIDTH-1:0] menor_vizinho_in,
  input  logic                   avaliar_in,
  input  logic                   modo_in,
  input  logic [CRIT_WIDTH-1:0]  limiar_in,
  input  logic [CRIT_WIDTH-1:0]  margem_in,
  output logic                   ocupado_out,
  output logic                   pronto_out,
  output logic [NUM_ATIVOS-1:0]  aprovados_out,
  output logic [CRIT_WIDTH-1:0]  menor_criterio_out,
  output logic [ADDR_WIDTH-1:0]  menor_indice_out,
  output logic                   vazio_out
);

  typedef enum logic [2:0] {
    IDLE,
    BUSCA,
    LIMIAR,
    MARCAR,
    FIM
  } estado_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_ULT =
    ADDR_WIDTH'(NUM_ATIVOS - 1);

  estado_t estado_q, estado_d;

  logic [NUM_ATIVOS-1:0]  valido_q, valido_d;
  logic [DIST_WIDTH-1:0]  dist_q  [NUM_ATIVOS];
  logic [DIST_WIDTH-1:0]  dist_d  [NUM_ATIVOS];
  logic [CUSTO_WIDTH-1:0] custo_q [NUM_ATIVOS];
  logic [CUSTO_WIDTH-1:0] custo_d [NUM_ATIVOS];

  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CRIT_WIDTH-1:0] min_q, min_d;
  logic [ADDR_WIDTH-1:0] min_idx_q, min_idx_d;
  logic                  achou_q, achou_d;

  logic                  modo_q, modo_d;
  logic [CRIT_WIDTH-1:0] limiar_q, limiar_d;
  logic [CRIT_WIDTH-1:0] margem_q, margem_d;
  logic [CRIT_WIDTH-1:0] thr_q, thr_d;

  logic [NUM_ATIVOS-1:0] aprov_q, aprov_d;
  logic [CRIT_WIDTH-1:0] menor_crit_q, menor_crit_d;
  logic [ADDR_WIDTH-1:0] menor_idx_q, menor_idx_d;
  logic                  vazio_q, vazio_d;
  logic                  ocupado_q, ocupado_d;
  logic                  pronto_q, pronto_d;

  logic [CRIT_WIDTH-1:0] crit [NUM_ATIVOS];
  logic [NUM_ATIVOS-1:0] aprova;
  logic [CRIT_WIDTH:0]   soma;
  logic                  addr_ok;

  // Criterion per slot; the extra bit of CRIT_WIDTH absorbs the carry.
  always_comb begin
    for (int i = 0; i < NUM_ATIVOS; i++) begin
      crit[i] = CRIT_WIDTH'(dist_q[i]) + CRIT_WIDTH'(custo_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ATIVOS; i++) begin
      aprova[i] = valido_q[i] && (crit[i] <= thr_q);
    end
  end

  assign soma    = {1'b0, min_q} + {1'b0, margem_q};
  assign addr_ok = int'(endereco_in) < NUM_ATIVOS;

  always_comb begin
    estado_d     = estado_q;
    valido_d     = valido_q;
    dist_d       = dist_q;
    custo_d      = custo_q;
    idx_d        = idx_q;
    min_d        = min_q;
    min_idx_d    = min_idx_q;
    achou_d      = achou_q;
    modo_d       = modo_q;
    limiar_d     = limiar_q;
    margem_d     = margem_q;
    thr_d        = thr_q;
    aprov_d      = aprov_q;
    menor_crit_d = menor_crit_q;
    menor_idx_d  = menor_idx_q;
    vazio_d      = vazio_q;

    unique case (estado_q)
      IDLE: begin
        if (escrever_in && addr_ok) begin
          valido_d[endereco_in] = 1'b1;
          dist_d[endereco_in]   = distancia_in;
          custo_d[endereco_in]  = menor_vizinho_in;
        end else if (limpar_in && addr_ok) begin
          valido_d[endereco_in] = 1'b0;
        end
        if (avaliar_in) begin
          estado_d  = BUSCA;
          modo_d    = modo_in;
          limiar_d  = limiar_in;
          margem_d  = margem_in;
          idx_d     = '0;
          min_d     = '1;
          min_idx_d = '0;
          achou_d   = 1'b0;
        end
      end
      BUSCA: begin
        // Strict < keeps the lowest index on ties.
        if (valido_q[idx_q] &&
            (!achou_q || crit[idx_q] < min_q)) begin
          min_d     = crit[idx_q];
          min_idx_d = idx_q;
          achou_d   = 1'b1;
        end
        if (idx_q == IDX_ULT) begin
          estado_d = LIMIAR;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LIMIAR: begin
        if (!modo_q) begin
          thr_d = limiar_q;
        end else if (!achou_q) begin
          // Nothing valid: the all-ones start value is not a minimum.
          thr_d = '0;
        end else if (soma[CRIT_WIDTH]) begin
          thr_d = '1;
        end else begin
          thr_d = soma[CRIT_WIDTH-1:0];
        end
        estado_d = MARCAR;
      end
      MARCAR: begin
        aprov_d      = aprova;
        menor_crit_d = min_q;
        menor_idx_d  = min_idx_q;
        vazio_d      = !achou_q;
        estado_d     = FIM;
      end
      FIM: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase

    ocupado_d = (estado_d != IDLE);
    pronto_d  = (estado_d == FIM);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      estado_q <= IDLE;
      valido_q <= '0;
      for (int i = 0; i < NUM_ATIVOS; i++) begin
        dist_q[i]  <= '0;
        custo_q[i] <= '0;
      end
      idx_q        <= '0;
      min_q        <= '1;
      min_idx_q    <= '0;
      achou_q      <= 1'b0;
      modo_q       <= 1'b0;
      limiar_q     <= '0;
      margem_q     <= '0;
      thr_q        <= '0;
      aprov_q      <= '0;
      menor_crit_q <= '0;
      menor_idx_q  <= '0;
      vazio_q      <= 1'b0;
      ocupado_q    <= 1'b0;
      pronto_q     <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      valido_q     <= valido_d;
      dist_q       <= dist_d;
      custo_q      <= custo_d;
      idx_q        <= idx_d;
      min_q        <= min_d;
      min_idx_q    <= min_idx_d;
      achou_q      <= achou_d;
      modo_q       <= modo_d;
      limiar_q     <= limiar_d;
      margem_q     <= margem_d;
      thr_q        <= thr_d;
      aprov_q      <= aprov_d;
      menor_crit_q <= menor_crit_d;
      menor_idx_q  <= menor_idx_d;
      vazio_q      <= vazio_d;
      ocupado_q    <= ocupado_d;
      pronto_q     <= pronto_d;
    end
  end

  assign ocupado_out        = ocupado_q;
  assign pronto_out         = pronto_q;
  assign aprovados_out      = aprov_q;
  assign menor_criterio_out = menor_crit_q;
  assign menor_indice_out   = menor_idx_q;
  assign vazio_out          = vazio_q;

endmodule

// File: tb/tb_avaliador_limiar.sv
// tb_avaliador_limiar: directed and random checks of avaliador_limiar
// against an arithmetic model of the node store and threshold rules.
module tb_avaliador_limiar;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 2;
  localparam int KW = 9;
  localparam int CMAX = 511;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          escrever = 1'b0;
  logic          limpar = 1'b0;
  logic [AW-1:0] endereco = '0;
  logic [DW-1:0] distancia = '0;
  logic [CW-1:0] vizinho = '0;
  logic          avaliar = 1'b0;
  logic          modo = 1'b0;
  logic [KW-1:0] limiar = '0;
  logic [KW-1:0] margem = '0;
  logic          ocupado;
  logic          pronto;
  logic [N-1:0]  aprovados;
  logic [KW-1:0] menor_crit;
  logic [AW-1:0] menor_idx;
  logic          vazio;

  int n_assert = 0;
  int n_fail   = 0;

  int  m_dist [N];
  int  m_cost [N];
  bit  m_val  [N];

  avaliador_limiar #(
    .NUM_ATIVOS (N),
    .DIST_WIDTH (DW),
    .CUSTO_WIDTH(CW)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .escrever_in       (escrever),
    .limpar_in         (limpar),
    .endereco_in       (endereco),
    .distancia_in      (distancia),
    .menor_vizinho_in  (vizinho),
    .avaliar_in        (avaliar),
    .modo_in           (modo),
    .limiar_in         (limiar),
    .margem_in         (margem),
    .ocupado_out       (ocupado),
    .pronto_out        (pronto),
    .aprovados_out     (aprovados),
    .menor_criterio_out(menor_crit),
    .menor_indice_out  (menor_idx),
    .vazio_out         (vazio)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < N; i++) m_val[i] = 1'b0;
  endtask

  task automatic escreve(input int a, input int d, input int c);
    escrever  = 1'b1;
    endereco  = AW'(a);
    distancia = DW'(d);
    vizinho   = CW'(c);
    step();
    escrever  = 1'b0;
    m_val[a]  = 1'b1;
    m_dist[a] = d;
    m_cost[a] = c;
  endtask

  task automatic limpa(input int a);
    limpar   = 1'b1;
    endereco = AW'(a);
    step();
    limpar   = 1'b0;
    m_val[a] = 1'b0;
  endtask

  // Optional poke: a write and a second avaliar while busy, both ignored.
  task automatic avalia(input string tag, input bit m, input int lim,
                        input int mar, input bit poke);
    int e_min, e_idx, thr, lat, k;
    bit e_vazio;
    int e_aprov;
    e_min   = CMAX;
    e_idx   = 0;
    e_vazio = 1'b1;
    for (int i = 0; i < N; i++) begin
      k = m_dist[i] + m_cost[i];
      if (m_val[i] && (e_vazio || k < e_min)) begin
        e_min   = k;
        e_idx   = i;
        e_vazio = 1'b0;
      end
    end
    if (m == 1'b0) thr = lim;
    else thr = (e_min + mar > CMAX) ? CMAX : e_min + mar;
    e_aprov = 0;
    for (int i = 0; i < N; i++) begin
      if (m_val[i] && (m_dist[i] + m_cost[i] <= thr))
        e_aprov = e_aprov | (1 << i);
    end
    modo    = m;
    limiar  = KW'(lim);
    margem  = KW'(mar);
    avaliar = 1'b1;
    step();
    avaliar = 1'b0;
    chk({tag, "_ocupado_ini"}, int'(ocupado), 1);
    lat = 1;
    if (poke) begin
      escrever  = 1'b1;
      avaliar   = 1'b1;
      endereco  = 2'd0;
      distancia = 8'd0;
      vizinho   = 8'd0;
      step();
      lat++;
      escrever  = 1'b0;
      avaliar   = 1'b0;
    end
    while (!pronto && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latencia"}, lat, N + 3);
    chk({tag, "_aprovados"}, int'(aprovados), e_aprov);
    chk({tag, "_menor_crit"}, int'(menor_crit), e_min);
    chk({tag, "_menor_idx"}, int'(menor_idx), e_idx);
    chk({tag, "_vazio"}, int'(vazio), int'(e_vazio));
    step();
    chk({tag, "_pronto_pulso"}, int'(pronto), 0);
    chk({tag, "_ocupado_fim"}, int'(ocupado), 0);
    chk({tag, "_aprov_hold"}, int'(aprovados), e_aprov);
  endtask

  initial begin
    int seen;
    model_clear_all();
    for (int i = 0; i < N; i++) begin
      m_dist[i] = 0;
      m_cost[i] = 0;
    end
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_aprov", int'(aprovados), 0);
    chk("rst_menor_crit", int'(menor_crit), 0);
    chk("rst_menor_idx", int'(menor_idx), 0);
    chk("rst_vazio", int'(vazio), 0);

    escreve(0, 3, 2);
    escreve(1, 1, 1);
    escreve(2, 4, 4);
    escreve(3, 2, 0);
    avalia("m1_mar1", 1'b1, 0, 1, 1'b0);
    chk("m1_lit_aprov", int'(aprovados), 4'b1010);
    avalia("m0_lim5", 1'b0, 5, 0, 1'b0);
    chk("m0_lit_aprov", int'(aprovados), 4'b1011);
    limpa(1);
    avalia("tie_limpa", 1'b1, 0, 0, 1'b0);
    chk("tie_lit_idx", int'(menor_idx), 3);

    escreve(2, 255, 255);
    avalia("sat", 1'b1, 0, 511, 1'b0);
    chk("sat_lit_bit2", int'(aprovados[2]), 1);

    avalia("busy_poke", 1'b0, 6, 0, 1'b1);
    avalia("busy_after", 1'b0, 6, 0, 1'b0);
    chk("busy_lit_slot0", int'(aprovados[0]), 1);
    step();
    step();
    chk("avaliar_nao_fila", int'(ocupado), 0);

    escrever  = 1'b1;
    limpar    = 1'b1;
    endereco  = 2'd1;
    distancia = 8'd0;
    vizinho   = 8'd1;
    step();
    escrever  = 1'b0;
    limpar    = 1'b0;
    m_val[1]  = 1'b1;
    m_dist[1] = 0;
    m_cost[1] = 1;
    avalia("wr_vence", 1'b1, 0, 0, 1'b0);

    modo    = 1'b1;
    margem  = 9'd3;
    avaliar = 1'b1;
    step();
    avaliar = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_async_ocupado", int'(ocupado), 0);
    step();
    rst = 1'b0;
    model_clear_all();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (pronto) seen++;
    end
    chk("rst_sem_pronto", seen, 0);
    avalia("vazio_m1", 1'b1, 0, 7, 1'b0);
    avalia("vazio_m0", 1'b0, 511, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < 3; w++) begin
        int a, op;
        a  = int'($urandom_range(N - 1, 0));
        op = int'($urandom_range(3, 0));
        if (op == 0) limpa(a);
        else if (op == 1) escreve(a, 255, int'($urandom_range(255, 200)));
        else escreve(a, int'($urandom_range(255, 0)),
                     int'($urandom_range(255, 0)));
      end
      avalia("rand", 1'($urandom_range(1, 0)),
             int'($urandom_range(511, 0)),
             int'($urandom_range(511, 0)), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
